// File: rtl/md5_cand_driver_if.sv
// Message/digest handshake between the candidate driver and one pancham MD5 core.
// The master drives candidate requests; the slave returns digests.
interface md5_cand_driver_if;
    logic [0:127] msg_in;
    logic [0:7]   msg_in_width;
    logic         msg_in_valid;
    logic [0:127] msg_output;
    logic         msg_out_valid;
    logic         ready;

    modport master (
        output msg_in, msg_in_width, msg_in_valid,
        input  msg_output, msg_out_valid, ready
    );

    modport slave (
        input  msg_in, msg_in_width, msg_in_valid,
        output msg_output, msg_out_valid, ready
    );
endinterface

// File: rtl/md5_cand_driver.sv
// Brute-force search engine: walks lowercase candidates in odometer order through
// pancham, one request at a time, and stops on a digest match or on exhaustion.
module md5_cand_driver #(
    parameter int MAX_LEN = 7,
    parameter int ATT_W   = 36
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         cfg_len,
    input  logic [0:127]       target_hash,
    md5_cand_driver_if.master  core,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               bad_cfg,
    output logic [0:127]       found_msg,
    output logic [ATT_W-1:0]   attempts
);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, WAIT_RES, DRAIN, FIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         len_q, len_d;
    logic [0:127]       target_q, target_d;
    logic [0:127]       cand_q, cand_d;
    logic [0:127]       msg_in_q, msg_in_d;
    logic [0:7]         width_q, width_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               found_q, found_d;
    logic               bad_q, bad_d;
    logic [0:127]       found_msg_q, found_msg_d;
    logic [ATT_W-1:0]   att_q, att_d;

    logic               cfg_ok;
    logic               last;
    logic               carry;
    logic [0:127]       cand_next;
    logic [0:127]       cand_init;

    assign cfg_ok = (cfg_len != 4'd0) && (int'(cfg_len) <= MAX_LEN);

    // Rightmost active character is the fastest digit; 'z' rolls to 'a' with carry.
    always_comb begin
        last      = 1'b1;
        carry     = 1'b1;
        cand_next = cand_q;
        cand_init = '0;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (i < int'(cfg_len))
                cand_init[8*i +: 8] = 8'h61;
            if (i < int'(len_q)) begin
                if (cand_q[8*i +: 8] != 8'h7a)
                    last = 1'b0;
                if (carry) begin
                    if (cand_q[8*i +: 8] == 8'h7a) begin
                        cand_next[8*i +: 8] = 8'h61;
                    end else begin
                        cand_next[8*i +: 8] = cand_q[8*i +: 8] + 8'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        target_d    = target_q;
        cand_d      = cand_q;
        msg_in_d    = msg_in_q;
        width_d     = width_q;
        done_d      = done_q;
        found_d     = found_q;
        bad_d       = bad_q;
        found_msg_d = found_msg_q;
        att_d       = att_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    att_d       = '0;
                    found_d     = 1'b0;
                    found_msg_d = '0;
                    if (cfg_ok) begin
                        len_d    = cfg_len;
                        target_d = target_hash;
                        cand_d   = cand_init;
                        done_d   = 1'b0;
                        bad_d    = 1'b0;
                        state_d  = WAIT_RDY;
                    end else begin
                        done_d   = 1'b1;
                        bad_d    = 1'b1;
                        state_d  = FIN;
                    end
                end
            end
            WAIT_RDY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (core.ready) begin
                    // Request bus is loaded only here so it stays stable across the wait for the digest.
                    msg_in_d = cand_q;
                    width_d  = {1'b0, len_q, 3'b000};
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = abort ? DRAIN : WAIT_RES;
            end
            WAIT_RES: begin
                if (abort) begin
                    // A digest arriving with the abort is the one being drained.
                    state_d = core.msg_out_valid ? IDLE : DRAIN;
                end else if (core.msg_out_valid) begin
                    att_d = (att_q == {ATT_W{1'b1}}) ? att_q : att_q + 1'b1;
                    if (core.msg_output == target_q) begin
                        found_d     = 1'b1;
                        found_msg_d = cand_q;
                        done_d      = 1'b1;
                        state_d     = FIN;
                    end else if (last) begin
                        found_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        cand_d  = cand_next;
                        state_d = WAIT_RDY;
                    end
                end
            end
            DRAIN: begin
                if (core.msg_out_valid)
                    state_d = IDLE;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == ISSUE);
        busy_d  = !(state_d inside {IDLE, FIN});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            target_q    <= '0;
            cand_q      <= '0;
            msg_in_q    <= '0;
            width_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            bad_q       <= 1'b0;
            found_msg_q <= '0;
            att_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            target_q    <= target_d;
            cand_q      <= cand_d;
            msg_in_q    <= msg_in_d;
            width_q     <= width_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            bad_q       <= bad_d;
            found_msg_q <= found_msg_d;
            att_q       <= att_d;
        end
    end

    assign core.msg_in       = msg_in_q;
    assign core.msg_in_width = width_q;
    assign core.msg_in_valid = valid_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign found             = found_q;
    assign bad_cfg           = bad_q;
    assign found_msg         = found_msg_q;
    assign attempts          = att_q;

endmodule

// File: tb/tb_md5_cand_driver.sv
// Bench for md5_cand_driver with a behavioural stand-in for pancham; the stand-in
// digest is an invertible mix of the message, so each candidate has a unique digest.
module tb_md5_cand_driver;
    localparam int MAX_LEN = 7;
    localparam int ATT_W   = 36;
    localparam logic [0:127] KEY = 128'h5a17_c3e9_0b24_d68f_91e2_47ac_3f50_b86d;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic [3:0]         cfg_len;
    logic [0:127]       target_hash;
    logic               busy, done, found, bad_cfg;
    logic [0:127]       found_msg;
    logic [ATT_W-1:0]   attempts;

    int n_chk = 0;
    int n_err = 0;

    md5_cand_driver_if bus();

    md5_cand_driver #(.MAX_LEN(MAX_LEN), .ATT_W(ATT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_len(cfg_len), .target_hash(target_hash), .core(bus.master),
        .busy(busy), .done(done), .found(found), .bad_cfg(bad_cfg),
        .found_msg(found_msg), .attempts(attempts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Candidate number idx of length len, from its base-26 digits (last char least significant).
    function automatic logic [0:127] cand_str(input int len, input longint idx);
        logic [0:127] v;
        longint r;
        v = '0;
        r = idx;
        for (int p = len - 1; p >= 0; p--) begin
            v[8*p +: 8] = 8'(8'h61 + (r % 26));
            r = r / 26;
        end
        return v;
    endfunction

    function automatic logic [0:127] digest(input logic [0:127] m, input logic [0:7] w);
        return {m[37:127], m[0:36]} ^ KEY ^ {120'b0, w};
    endfunction

    // Core stand-in: random latency, ready withheld while a digest is pending.
    logic         core_busy;
    logic         rdy_en;
    int           lat;
    logic [0:127] lat_msg;
    logic [0:7]   lat_w;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_busy          <= 1'b0;
            rdy_en             <= 1'b1;
            lat                <= 0;
            lat_msg            <= '0;
            lat_w              <= '0;
            bus.msg_out_valid  <= 1'b0;
            bus.msg_output     <= '0;
        end else begin
            bus.msg_out_valid <= 1'b0;
            rdy_en            <= ($urandom_range(0, 3) != 0);
            if (bus.msg_in_valid) begin
                core_busy <= 1'b1;
                lat       <= $urandom_range(2, 6);
                lat_msg   <= bus.msg_in;
                lat_w     <= bus.msg_in_width;
            end else if (core_busy) begin
                if (lat == 0) begin
                    bus.msg_out_valid <= 1'b1;
                    bus.msg_output    <= digest(lat_msg, lat_w);
                    core_busy         <= 1'b0;
                end else begin
                    lat <= lat - 1;
                end
            end
        end
    end

    assign bus.ready = !core_busy && rdy_en;

    // Every request must be the next candidate in sequence and never overlap a pending one.
    int issued = 0;
    int base   = 0;
    int cur_len = 1;

    always @(negedge clk) begin
        if (bus.msg_in_valid) begin
            chk("cand", bus.msg_in, cand_str(cur_len, longint'(issued - base)));
            chk("width", 128'(bus.msg_in_width), 128'(8 * cur_len));
            chk("one_outstanding", 128'(core_busy), 128'(0));
            issued++;
        end
    end

    task automatic pulse_start(input int len, input logic [0:127] tgt);
        @(negedge clk);
        cfg_len     = 4'(len);
        target_hash = tgt;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 20000 && !done; c++) @(negedge clk);
        chk(tag, 128'(done), 128'(1));
    endtask

    // Search for candidate idx (or exhaust the space); optionally poke a start mid-search.
    task automatic run_search(input int len, input longint idx, input bit exhaust, input bit poke);
        logic [0:127] tgt;
        longint exp_att;
        tgt = exhaust ? '0 : digest(cand_str(len, idx), 8'(8 * len));
        exp_att = exhaust ? 26 ** len : idx + 1;
        cur_len = len;
        base    = issued;
        pulse_start(len, tgt);
        if (poke) begin
            repeat (20) @(negedge clk);
            chk("poke_busy", 128'(busy), 128'(1));
            start       = 1'b1;
            cfg_len     = 4'd1;
            target_hash = digest(cand_str(1, 0), 8'd8);
            @(negedge clk);
            start       = 1'b0;
        end
        wait_done("done_timeout");
        chk("found", 128'(found), 128'(!exhaust));
        chk("attempts", 128'(attempts), 128'(exp_att));
        chk("issued", 128'(issued - base), 128'(exp_att));
        chk("found_msg", found_msg, exhaust ? 128'(0) : cand_str(len, idx));
        chk("bad_cfg", 128'(bad_cfg), 128'(0));
        @(negedge clk);
        chk("busy_after", 128'(busy), 128'(0));
        chk("done_hold", 128'(done), 128'(1));
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_len     = '0;
        target_hash = '0;
        #1;
        chk("rst_msg_in", bus.msg_in, 128'(0));
        chk("rst_valid", 128'(bus.msg_in_valid), 128'(0));
        chk("rst_flags", {busy, done, found, bad_cfg}, 128'(0));
        chk("rst_att", 128'(attempts), 128'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // First candidate, odometer carry through aaz->aba, and the longest length.
        run_search(1, 0, 1'b0, 1'b0);
        chk("width_len1", 128'(bus.msg_in_width), 128'(8));
        run_search(3, 28, 1'b0, 1'b0);
        run_search(MAX_LEN, 27, 1'b0, 1'b0);

        // Exhaustion: last request is "z".
        run_search(1, 0, 1'b1, 1'b0);
        chk("last_msg_in", bus.msg_in, cand_str(1, 25));

        // Random targets; one run also checks that a start while busy is ignored.
        for (int k = 0; k < 4; k++)
            run_search(2, longint'($urandom_range(0, 150)), 1'b0, k == 1);
        run_search(1, longint'($urandom_range(0, 25)), 1'b0, 1'b0);

        // Abort while the 5th digest is pending.
        cur_len = 2;
        base    = issued;
        pulse_start(2, '1);
        for (int c = 0; c < 2000 && (issued - base) < 5; c++) @(negedge clk);
        chk("abort_reach5", 128'(issued - base), 128'(5));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(0));
        repeat (30) @(negedge clk);
        chk("abort_no_issue", 128'(issued - base), 128'(5));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_att", 128'(attempts), 128'(4));
        run_search(1, 0, 1'b0, 1'b0);

        // Out-of-range lengths.
        for (int b = 0; b < 2; b++) begin
            base = issued;
            pulse_start(b == 0 ? 0 : MAX_LEN + 1, '0);
            chk("bad_done", 128'(done), 128'(1));
            chk("bad_cfg", 128'(bad_cfg), 128'(1));
            chk("bad_found", 128'(found), 128'(0));
            repeat (10) @(negedge clk);
            chk("bad_no_issue", 128'(issued - base), 128'(0));
        end

        // Asynchronous reset while a digest is pending, then a clean restart.
        cur_len = 2;
        base    = issued;
        pulse_start(2, digest(cand_str(2, 600), 8'd16));
        for (int c = 0; c < 2000 && (issued - base) < 3; c++) @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_msg_in", bus.msg_in, 128'(0));
        chk("mid_rst_width", 128'(bus.msg_in_width), 128'(0));
        chk("mid_rst_flags", {bus.msg_in_valid, busy, done, found, bad_cfg}, 128'(0));
        chk("mid_rst_found_msg", found_msg, 128'(0));
        chk("mid_rst_att", 128'(attempts), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        run_search(2, 30, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
